// File: rtl/gost_89_gamma_ctrl.sv
// Gamma-mode sequencer around an external encrypt-only GOST 28147-89 block core.
// Define GOST_GAMMA_FEEDBACK_EN to add gamma-with-feedback (selected by fb_mode at iv_load).
module gost_89_gamma_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [255:0] key,
    input  logic         iv_load,
    input  logic [63:0]  iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic         dec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         sync_ok,
    output logic         err,
    output logic         core_load,
    output logic         core_mode,
    output logic         core_kload,
    output logic [255:0] core_key,
    output logic [63:0]  core_pdata,
    input  logic         core_done,
    input  logic [63:0]  core_cdata,
    input  logic         fb_mode
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PRE_LOAD = 3'd1;
    localparam logic [2:0] PRE_WAIT = 3'd2;
    localparam logic [2:0] READY    = 3'd3;
    localparam logic [2:0] BLK_LOAD = 3'd4;
    localparam logic [2:0] BLK_WAIT = 3'd5;
    localparam logic [2:0] OUT_HOLD = 3'd6;

    localparam logic [31:0] C1 = 32'h0101_0101;
    localparam logic [32:0] C2 = 33'h0_0101_0104;
    // Counter is cleared on the load cycle L, so it reads 32 in cycle L+33.
    localparam logic [5:0]  CAPTURE_CNT = 6'd32;

    logic [2:0]   state_reg;
    logic [5:0]   cnt_reg;
    logic [31:0]  n3_reg;
    logic [31:0]  n4_reg;
    logic [63:0]  in_lat_reg;
    logic [63:0]  out_data_reg;
    logic         out_valid_reg;
    logic         core_load_reg;
    logic         core_kload_reg;
    logic [255:0] core_key_reg;
    logic [63:0]  core_pdata_reg;
    logic         sync_ok_reg;
    logic         err_reg;

    logic [31:0]  n3_next;
    logic [32:0]  n4_sum;
    logic [31:0]  n4_next;
    logic         key_accept;
    logic         iv_accept;
    logic         at_capture;
    logic         blk_start;
    logic         blk_capture;
    logic         use_fb;
    logic [63:0]  fb_pdata;

    assign key_accept  = key_load && (state_reg == IDLE || state_reg == READY);
    assign iv_accept   = iv_load && !key_accept;
    assign at_capture  = (cnt_reg == CAPTURE_CNT);
    assign blk_start   = !key_accept && !iv_accept && state_reg == READY && in_valid;
    assign blk_capture = !key_accept && !iv_accept && state_reg == BLK_WAIT && at_capture;

    // n4 steps modulo 2^32-1: an end-around carry folds bit 32 back into bit 0.
    assign n3_next = n3_reg + C1;
    assign n4_sum  = {1'b0, n4_reg} + C2;
    assign n4_next = n4_sum[32] ? (n4_sum[31:0] + 32'd1) : n4_sum[31:0];

`ifdef GOST_GAMMA_FEEDBACK_EN
    logic         fb_mode_reg;
    logic [63:0]  fb_reg;
    logic         dec_reg;

    assign use_fb   = fb_mode_reg;
    assign fb_pdata = fb_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_mode_reg <= 1'b0;
            fb_reg      <= 64'd0;
            dec_reg     <= 1'b0;
        end else if (iv_accept) begin
            fb_mode_reg <= fb_mode;
            fb_reg      <= iv;
        end else if (blk_start) begin
            dec_reg <= dec;
        end else if (blk_capture && fb_mode_reg) begin
            // Feedback always carries the ciphertext, whichever direction we run.
            fb_reg <= dec_reg ? in_lat_reg : (in_lat_reg ^ core_cdata);
        end
    end
`else
    logic unused_fb_inputs;

    assign use_fb           = 1'b0;
    assign fb_pdata         = 64'd0;
    assign unused_fb_inputs = fb_mode ^ dec;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 6'd0;
            n3_reg         <= 32'd0;
            n4_reg         <= 32'd0;
            in_lat_reg     <= 64'd0;
            out_data_reg   <= 64'd0;
            out_valid_reg  <= 1'b0;
            core_load_reg  <= 1'b0;
            core_kload_reg <= 1'b0;
            core_key_reg   <= 256'd0;
            core_pdata_reg <= 64'd0;
            sync_ok_reg    <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            core_load_reg  <= 1'b0;
            core_kload_reg <= 1'b0;
            if (key_accept) begin
                core_kload_reg <= 1'b1;
                core_key_reg   <= key;
                sync_ok_reg    <= 1'b0;
                state_reg      <= IDLE;
            end else if (iv_accept) begin
                core_load_reg  <= 1'b1;
                core_pdata_reg <= iv;
                sync_ok_reg    <= 1'b0;
                out_valid_reg  <= 1'b0;
                state_reg      <= PRE_LOAD;
            end else begin
                case (state_reg)
                    PRE_LOAD: begin
                        cnt_reg   <= 6'd0;
                        state_reg <= PRE_WAIT;
                    end
                    PRE_WAIT: begin
                        if (at_capture) begin
                            n4_reg      <= core_cdata[63:32];
                            n3_reg      <= core_cdata[31:0];
                            sync_ok_reg <= 1'b1;
                            if (!core_done)
                                err_reg <= 1'b1;
                            state_reg <= READY;
                        end else begin
                            cnt_reg <= cnt_reg + 6'd1;
                        end
                    end
                    READY: begin
                        if (in_valid) begin
                            in_lat_reg    <= in_data;
                            core_load_reg <= 1'b1;
                            if (use_fb) begin
                                core_pdata_reg <= fb_pdata;
                            end else begin
                                n3_reg         <= n3_next;
                                n4_reg         <= n4_next;
                                core_pdata_reg <= {n4_next, n3_next};
                            end
                            state_reg <= BLK_LOAD;
                        end
                    end
                    BLK_LOAD: begin
                        cnt_reg   <= 6'd0;
                        state_reg <= BLK_WAIT;
                    end
                    BLK_WAIT: begin
                        if (at_capture) begin
                            out_data_reg  <= in_lat_reg ^ core_cdata;
                            out_valid_reg <= 1'b1;
                            if (!core_done)
                                err_reg <= 1'b1;
                            state_reg <= OUT_HOLD;
                        end else begin
                            cnt_reg <= cnt_reg + 6'd1;
                        end
                    end
                    OUT_HOLD: begin
                        if (out_ready) begin
                            out_valid_reg <= 1'b0;
                            state_reg     <= READY;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign in_ready   = (state_reg == READY);
    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign sync_ok    = sync_ok_reg;
    assign err        = err_reg;
    assign core_load  = core_load_reg;
    assign core_mode  = 1'b0;
    assign core_kload = core_kload_reg;
    assign core_key   = core_key_reg;
    assign core_pdata = core_pdata_reg;

endmodule

// File: tb/tb_gost_89_gamma_ctrl.sv
// Directed bench for gost_89_gamma_ctrl with a toy 33-cycle core model.
// Also covers gamma-with-feedback when GOST_GAMMA_FEEDBACK_EN is defined.
module tb_gost_89_gamma_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_load = 1'b0;
    logic [255:0] key = '0;
    logic         iv_load = 1'b0;
    logic [63:0]  iv = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_data = '0;
    logic         dec = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [63:0]  out_data;
    logic         sync_ok;
    logic         err;
    logic         core_load;
    logic         core_mode;
    logic         core_kload;
    logic [255:0] core_key;
    logic [63:0]  core_pdata;
    logic         core_done = 1'b0;
    logic [63:0]  core_cdata = '0;
    logic         fb_mode = 1'b0;

    int errors = 0;
    int checks = 0;

    // core model controls
    logic         omit_done = 1'b0;
    logic         force_en = 1'b0;
    logic [63:0]  force_val = '0;
    logic [63:0]  m_pdata = '0;
    int           m_cnt = 0;

    // bench copy of the counter
    logic [31:0]  m_n3;
    logic [31:0]  m_n4;

    localparam logic [255:0] KEY0 = 256'h1F;
    localparam logic [63:0]  S0   = 64'h1234_5678_90AB_CDEF;
    localparam logic [63:0]  S3   = 64'hCAFE_F00D_DEAD_BEEF;

    gost_89_gamma_ctrl dut (
        .clk(clk), .rst(rst),
        .key_load(key_load), .key(key),
        .iv_load(iv_load), .iv(iv),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .dec(dec),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sync_ok(sync_ok), .err(err),
        .core_load(core_load), .core_mode(core_mode), .core_kload(core_kload),
        .core_key(core_key), .core_pdata(core_pdata),
        .core_done(core_done), .core_cdata(core_cdata),
        .fb_mode(fb_mode)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_e(input logic [63:0] p);
        return {p[22:0], p[63:23]} ^ 64'h5A5A_3C3C_0F0F_1F1F;
    endfunction

    // Core answers in cycle L+33; it deliberately ignores rst so stale answers can occur.
    always @(posedge clk) begin
        if (core_load) begin
            m_pdata   <= core_pdata;
            m_cnt     <= 1;
            core_done <= 1'b0;
        end else if (m_cnt == 32) begin
            m_cnt      <= 0;
            core_done  <= !omit_done;
            core_cdata <= force_en ? force_val : model_e(m_pdata);
        end else begin
            core_done <= 1'b0;
            if (m_cnt != 0)
                m_cnt <= m_cnt + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ctr_init(input logic [63:0] e);
        m_n4 = e[63:32];
        m_n3 = e[31:0];
    endtask

    task automatic ctr_step(output logic [63:0] nv);
        logic [63:0] t;
        m_n3 = m_n3 + 32'h0101_0101;
        t = {32'd0, m_n4} + 64'h0101_0104;
        if (t >= 64'h1_0000_0000)
            t = t - 64'h1_0000_0000 + 64'd1;
        m_n4 = t[31:0];
        nv = {m_n4, m_n3};
    endtask

    task automatic load_key(input logic [255:0] k);
        @(negedge clk); key = k; key_load = 1'b1;
        @(negedge clk); key_load = 1'b0;
        chk("kload_pulse", core_kload, 1);
        chk("core_key", core_key, k);
        @(negedge clk);
        chk("kload_off", core_kload, 0);
    endtask

    task automatic load_iv(input logic [63:0] s, input logic fbm);
        @(negedge clk); iv = s; fb_mode = fbm; iv_load = 1'b1;
        @(negedge clk); iv_load = 1'b0;
    endtask

    task automatic wait_sync();
        int n = 0;
        while (sync_ok !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        chk("sync_seen", sync_ok, 1);
    endtask

    task automatic start_block(input logic [63:0] d, input logic dc, output logic [63:0] pd);
        int n = 0;
        while (in_ready !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        chk("in_ready_seen", in_ready, 1);
        in_valid = 1'b1; in_data = d; dec = dc;
        @(negedge clk); in_valid = 1'b0;
        chk("blk_core_load", core_load, 1);
        pd = core_pdata;
    endtask

    task automatic wait_out(output logic [63:0] d);
        int n = 0;
        while (out_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        chk("out_valid_seen", out_valid, 1);
        d = out_data;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] pt [4];
        logic [63:0] ct [4];
        logic [63:0] pd, exp_pd, c, r, d0;
        logic        flag;

        pt[0] = 64'h0000_0000_0000_0000;
        pt[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        pt[2] = 64'h0123_4567_89AB_CDEF;
        pt[3] = 64'hA5A5_5A5A_C3C3_3C3C;

        // reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_flags", {in_ready, out_valid, core_load, core_kload, sync_ok, err, core_mode}, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_core_pdata", core_pdata, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 0);

        load_key(KEY0);

        // timing: iv_load in cycle T
        load_iv(S0, 1'b0);
        chk("pre_core_load", core_load, 1);
        chk("pre_core_pdata", core_pdata, S0);
        @(negedge clk);
        chk("pre_load_one_cycle", core_load, 0);
        repeat (32) @(negedge clk);
        chk("sync_T34", sync_ok, 0);
        @(negedge clk);
        chk("sync_T35", sync_ok, 1);
        chk("ready_in_ready", in_ready, 1);

        // counter gamma encrypt
        ctr_init(model_e(S0));
        for (int i = 0; i < 4; i++) begin
            ctr_step(exp_pd);
            start_block(pt[i], 1'b0, pd);
            chk($sformatf("enc_pdata%0d", i), pd, exp_pd);
            wait_out(c);
            ack();
            chk($sformatf("enc_out%0d", i), c, pt[i] ^ model_e(exp_pd));
            ct[i] = c;
        end
        load_iv(S0, 1'b0);
        wait_sync();
        for (int i = 0; i < 4; i++) begin
            start_block(ct[i], 1'b1, pd);
            wait_out(r);
            ack();
            chk($sformatf("dec_out%0d", i), r, pt[i]);
        end
        chk("err_clear", err, 0);

        // n4 wrap-around
        force_en = 1'b1; force_val = 64'hFFFF_FFFF_0000_0000;
        load_iv(S0, 1'b0);
        wait_sync();
        force_en = 1'b0;
        start_block(pt[2], 1'b0, pd);
        chk("wrap_carry", pd, 64'h0101_0104_0101_0101);
        wait_out(c); ack();
        force_en = 1'b1; force_val = 64'hFEFE_FEFB_FFFF_FFFF;
        load_iv(S0, 1'b0);
        wait_sync();
        force_en = 1'b0;
        start_block(pt[2], 1'b0, pd);
        chk("wrap_nocarry", pd, 64'hFFFF_FFFF_0101_0100);
        wait_out(c); ack();

        // backpressure
        start_block(pt[3], 1'b0, pd);
        wait_out(d0);
        flag = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_data !== d0 || out_valid !== 1'b1 || in_ready !== 1'b0)
                flag = 1'b0;
        end
        chk("bp_stable", flag, 1);
        out_ready = 1'b1;
        chk("bp_hs_in_ready", in_ready, 0);
        @(negedge clk); out_ready = 1'b0;
        chk("bp_after_valid", out_valid, 0);
        chk("bp_after_in_ready", in_ready, 1);

        // abort during BLK_WAIT
        start_block(pt[1], 1'b0, pd);
        repeat (10) @(negedge clk);
        iv = S3; iv_load = 1'b1;
        @(negedge clk); iv_load = 1'b0;
        chk("abort_core_load", core_load, 1);
        chk("abort_core_pdata", core_pdata, S3);
        flag = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0)
                flag = 1'b1;
        end
        chk("abort_no_out", flag, 0);
        chk("abort_resync", sync_ok, 1);

        // missing core_done at capture
        omit_done = 1'b1;
        load_iv(S0, 1'b0);
        wait_sync();
        omit_done = 1'b0;
        chk("err_set", err, 1);
        load_iv(S0, 1'b0);
        wait_sync();
        chk("err_sticky", err, 1);

`ifdef GOST_GAMMA_FEEDBACK_EN
        // feedback gamma round trip
        load_iv(S0, 1'b1);
        wait_sync();
        exp_pd = S0;
        for (int i = 0; i < 4; i++) begin
            start_block(pt[i], 1'b0, pd);
            chk($sformatf("fb_enc_pdata%0d", i), pd, exp_pd);
            wait_out(c);
            ack();
            chk($sformatf("fb_enc_out%0d", i), c, pt[i] ^ model_e(exp_pd));
            ct[i] = c;
            exp_pd = c;
        end
        load_iv(S0, 1'b1);
        wait_sync();
        for (int i = 0; i < 4; i++) begin
            start_block(ct[i], 1'b1, pd);
            wait_out(r);
            ack();
            chk($sformatf("fb_dec_out%0d", i), r, pt[i]);
        end
`else
        // fb_mode must be ignored: counter gamma still used
        load_iv(S0, 1'b1);
        wait_sync();
        ctr_init(model_e(S0));
        ctr_step(exp_pd);
        start_block(pt[2], 1'b0, pd);
        chk("fbm_ignored_pdata", pd, exp_pd);
        wait_out(c);
        ack();
        chk("fbm_ignored_out", c, pt[2] ^ model_e(exp_pd));
`endif

        // reset mid-BLK_WAIT
        start_block(pt[0], 1'b0, pd);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_flags", {in_ready, out_valid, core_load, core_kload, sync_ok, err}, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_core_pdata", core_pdata, 0);
        chk("mid_rst_core_key", core_key, 0);
        flag = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 2)
                rst = 1'b0;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || sync_ok !== 1'b0 || core_load !== 1'b0)
                flag = 1'b1;
        end
        chk("post_rst_quiet", flag, 0);
        load_key(KEY0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
